// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the mips_core datapath.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the register-file and memory strobes, the datapath mux selects and
// the PC update, and it handshakes with instruction and data memory.
// An illegal opcode or a memory timeout puts the FSM into a sticky HALT.
// Optional feature macro: MIPS_CTRL_PERF_EN adds the cycle and retire counters
// cyc_cnt and ret_cnt.
//
// state  | meaning
// FETCH  | request the instruction word, load IR when imem_ready arrives
// DECODE | classify the opcode, with no strobes this cycle
// EXEC   | ALU operation; branches and jumps retire here
// MEM    | data memory access, held until dmem_ready arrives
// WB     | register write-back and PC+4
// HALT   | sticky stop, left only through rst
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       rs_eq_rt,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic       ext_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_done,
  output logic       halted,
  output logic       err
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic is_r, is_jr, is_load, is_store, is_lui, is_beq, is_bne, is_j, is_jal;
  logic is_alui, is_zext, is_legal, is_to_wb, taken;

  // Instruction class from the opcode, which is held stable from DECODE to the next FETCH.
  always_comb begin
    is_r     = (opcode == 6'b000000);
    is_jr    = is_r && (funct == 6'b001000);
    is_load  = (opcode == 6'b100011) || (opcode == 6'b100100) ||
               (opcode == 6'b100101) || (opcode == 6'b110000);
    is_store = (opcode == 6'b101000) || (opcode == 6'b101001) ||
               (opcode == 6'b111000) || (opcode == 6'b101011);
    is_lui   = (opcode == 6'b001111);
    is_beq   = (opcode == 6'b000100);
    is_bne   = (opcode == 6'b000101);
    is_j     = (opcode == 6'b000010);
    is_jal   = (opcode == 6'b000011);
    is_alui  = (opcode >= 6'b001000) && (opcode <= 6'b001110);
    is_zext  = (opcode == 6'b001100) || (opcode == 6'b001101);
    is_legal = is_r || is_load || is_store || is_lui || is_beq || is_bne ||
               is_j || is_jal || is_alui;
    is_to_wb = (is_r && !is_jr) || is_alui || is_lui;
    taken    = (is_beq && rs_eq_rt) || (is_bne && !rs_eq_rt);
  end

  // Strobes and selects. Reset masks them so that a write in flight is dropped.
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    ext_zero    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        S_EXEC: begin
          alu_src_imm = !is_r;
          ext_zero    = is_zext;
          if (is_jr || is_beq || is_bne || is_j || is_jal) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
          if (is_jr) pc_sel = 2'd3;
          else if (is_j || is_jal) pc_sel = 2'd2;
          else if (taken) pc_sel = 2'd1;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wb_sel    = 2'd3;
          end
        end
        S_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
          if (is_store && dmem_ready) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_r ? 2'd1 : 2'd0;
          wb_sel     = is_load ? 2'd1 : (is_lui ? 2'd2 : 2'd0);
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state, memory wait counter and the sticky halt/err flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_MAX) begin
            state  <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_load || is_store) state <= S_MEM;
          else if (is_to_wb) state <= S_WB;
          else state <= S_FETCH;
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            state    <= is_load ? S_WB : S_FETCH;
          end else if (wait_cnt == WAIT_MAX) begin
            state  <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  // Counters for running cycles and retired instructions. Both wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (instr_done) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl.
// Each directed instruction pushes the output events it should produce.
// An event is a cycle with any strobe active, or the cycle in which halted rises.
// For each event the bench records the full output word and the number of quiet
// cycles since the previous event, so latency is checked as well.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       rs_eq_rt, imem_ready, dmem_ready;
  logic       imem_req, ir_write, pc_write, reg_write, alu_src_imm, ext_zero;
  logic       mem_read, mem_write, instr_done, halted, err;
  logic [1:0] pc_sel, reg_dst, wb_sel;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rs_eq_rt(rs_eq_rt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .ext_zero(ext_zero),
    .mem_read(mem_read), .mem_write(mem_write), .instr_done(instr_done),
    .halted(halted), .err(err)
`ifdef MIPS_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output word: [16]req [15]irw [14]pcw [13:12]pc_sel [11]rw [10:9]dst [8:7]wb
  //              [6]alu_imm [5]ext_zero [4]mr [3]mw [2]done [1]halted [0]err
  localparam logic [16:0] REQ  = 17'h10000;
  localparam logic [16:0] IRW  = 17'h08000;
  localparam logic [16:0] PCW  = 17'h04000;
  localparam logic [16:0] RW   = 17'h00800;
  localparam logic [16:0] ALU  = 17'h00040;
  localparam logic [16:0] EZ   = 17'h00020;
  localparam logic [16:0] MR   = 17'h00010;
  localparam logic [16:0] MW   = 17'h00008;
  localparam logic [16:0] DONE = 17'h00004;
  localparam logic [16:0] HLT  = 17'h00002;
  localparam logic [16:0] ERR  = 17'h00001;

  function automatic logic [16:0] psel(input int n); return 17'(n) << 12; endfunction
  function automatic logic [16:0] dst(input int n);  return 17'(n) << 9;  endfunction
  function automatic logic [16:0] wbs(input int n);  return 17'(n) << 7;  endfunction

  typedef struct {
    string       tag;
    logic [16:0] vec;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_ev(input string tag, input logic [16:0] v, input int gap);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
  endtask

`ifdef MIPS_CTRL_PERF_EN
  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask
`endif

  // Monitor: pops one expected event per DUT event and compares the word and the gap.
  initial begin
    int          gap;
    logic        hq;
    logic [16:0] v;
    exp_t        e;
    gap = 0;
    hq  = 1'b0;
    forever begin
      @(negedge clk);
      v = {imem_req, ir_write, pc_write, pc_sel, reg_write, reg_dst, wb_sel,
           alu_src_imm, ext_zero, mem_read, mem_write, instr_done, halted, err};
      if ((|v[16:2]) || (v[1] === 1'b1 && hq !== 1'b1)) begin
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_event got=%h gap=%0d", v, gap);
        end else begin
          e = q.pop_front();
          if (v !== e.vec || gap != e.gap) begin
            n_miss++;
            $display("FAIL %s got vec=%h gap=%0d expected vec=%h gap=%0d",
                     e.tag, v, gap, e.vec, e.gap);
          end
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (rst) gap = 0;
      hq = v[1];
    end
  end

  initial begin
    opcode = 6'd0; funct = 6'd0; rs_eq_rt = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    do_reset();

    // add: 4 cycles, write-back to rd
    funct = 6'b100000;
    expect_ev("add_fetch", REQ | IRW, 0);
    expect_ev("add_wb", RW | dst(1) | PCW | DONE, 2);
    rst = 1'b0;
    step(4);

    // lw with dmem_ready held back for 3 cycles: 8 cycles in total
    opcode = 6'b100011; dmem_ready = 1'b0;
    expect_ev("lw_fetch", REQ | IRW, 0);
    expect_ev("lw_exec", ALU, 1);
    for (int i = 0; i < 4; i++) expect_ev("lw_mem", MR, 0);
    expect_ev("lw_wb", RW | wbs(1) | PCW | DONE, 0);
    step(6);
    dmem_ready = 1'b1;
    step(2);

    // branches
    opcode = 6'b000100; rs_eq_rt = 1'b1;
    expect_ev("beq_t_fetch", REQ | IRW, 0);
    expect_ev("beq_taken", ALU | PCW | psel(1) | DONE, 1);
    step(3);
    rs_eq_rt = 1'b0;
    expect_ev("beq_nt_fetch", REQ | IRW, 0);
    expect_ev("beq_not_taken", ALU | PCW | DONE, 1);
    step(3);
    opcode = 6'b000101;
    expect_ev("bne_fetch", REQ | IRW, 0);
    expect_ev("bne_taken", ALU | PCW | psel(1) | DONE, 1);
    step(3);

    // jumps
    opcode = 6'b000010;
    expect_ev("j_fetch", REQ | IRW, 0);
    expect_ev("j_exec", ALU | PCW | psel(2) | DONE, 1);
    step(3);
    opcode = 6'b000011;
    expect_ev("jal_fetch", REQ | IRW, 0);
    expect_ev("jal_exec", ALU | RW | dst(2) | wbs(3) | PCW | psel(2) | DONE, 1);
    step(3);
    opcode = 6'b000000; funct = 6'b001000;
    expect_ev("jr_fetch", REQ | IRW, 0);
    expect_ev("jr_exec", PCW | psel(3) | DONE, 1);
    step(3);

    // ori (zero-extended immediate), lui, sw
    opcode = 6'b001101;
    expect_ev("ori_fetch", REQ | IRW, 0);
    expect_ev("ori_exec", ALU | EZ, 1);
    expect_ev("ori_wb", RW | PCW | DONE, 0);
    step(4);
    opcode = 6'b001111;
    expect_ev("lui_fetch", REQ | IRW, 0);
    expect_ev("lui_exec", ALU, 1);
    expect_ev("lui_wb", RW | wbs(2) | PCW | DONE, 0);
    step(4);
    opcode = 6'b101011;
    expect_ev("sw_fetch", REQ | IRW, 0);
    expect_ev("sw_exec", ALU, 1);
    expect_ev("sw_mem", MW | PCW | DONE, 0);
    step(4);

    // imem_ready arrives while the wait counter equals MEM_WAIT_MAX: still accepted
    opcode = 6'b000010; imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) expect_ev("fetch_wait", REQ, 0);
    expect_ev("fetch_last_ok", REQ | IRW, 0);
    expect_ev("j_after_wait", ALU | PCW | psel(2) | DONE, 1);
    step(15);
    imem_ready = 1'b1;
    step(3);

    // illegal opcode: HALT after DECODE with err=0, then silence
    opcode = 6'b111111;
    expect_ev("ill_fetch", REQ | IRW, 0);
    expect_ev("ill_halt", HLT, 1);
    step(6);
    do_reset();

    // instruction fetch timeout
    opcode = 6'b000000; funct = 6'b100000; imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) expect_ev("imem_wait", REQ, 0);
    expect_ev("imem_timeout", HLT | ERR, 0);
    rst = 1'b0;
    step(20);
    do_reset();

    // data memory timeout on a store
    imem_ready = 1'b1; dmem_ready = 1'b0; opcode = 6'b101011;
    expect_ev("sw_to_fetch", REQ | IRW, 0);
    expect_ev("sw_to_exec", ALU, 1);
    for (int i = 0; i < 16; i++) expect_ev("dmem_wait", MW, 0);
    expect_ev("dmem_timeout", HLT | ERR, 0);
    rst = 1'b0;
    step(22);
    do_reset();

    // reset pulse during MEM of a store: write dropped, FETCH next
    expect_ev("swr_fetch", REQ | IRW, 0);
    expect_ev("swr_exec", ALU, 1);
    expect_ev("swr_mem", MW, 0);
    rst = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0; dmem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100000;
`ifdef MIPS_CTRL_PERF_EN
    chk32("cyc_cnt_reset", cyc_cnt, 32'd0);
    chk32("ret_cnt_reset", ret_cnt, 32'd0);
`endif
    expect_ev("post_rst_fetch", REQ | IRW, 0);
    expect_ev("post_rst_wb", RW | dst(1) | PCW | DONE, 2);
    step(4);
`ifdef MIPS_CTRL_PERF_EN
    chk32("cyc_cnt_add", cyc_cnt, 32'd4);
    chk32("ret_cnt_add", ret_cnt, 32'd1);
`endif
    rst = 1'b1;
    step(3);

    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL missing_events got=%0d pending expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
